// File: rtl/alu_arbitro_pkg.sv
// Purpose: shared constants, opcode/state encodings and response payload for
//          the ALU arbiter (alu_arbitro) and its round-robin picker.
// Contents: ALU_W/RES_W/OP_W/CNT_W widths, alu_op_e opcodes, state_e FSM
//           states, resp_t captured-response payload, opcode class helpers.
package alu_arbitro_pkg;

  localparam int unsigned ALU_W = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_SUM = 3'd0,
    OP_RES = 3'd1,
    OP_PRO = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;
  } resp_t;

  // Ops that can trap on a zero divisor
  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // Ops whose carry/borrow flag is meaningful
  function automatic logic has_carry(input alu_op_e op);
    return (op == OP_SUM) || (op == OP_RES);
  endfunction

endpackage

// File: rtl/alu_arbitro_rr.sv
// Purpose: combinational round-robin picker; selects the first asserted
//          request at or above the pointer, wrapping past N_REQ-1 to 0.
// Ports:   i_req       request vector
//          i_ptr       search start index (always < N_REQ)
//          o_gnt       one-hot grant
//          o_gnt_idx   encoded grant index
//          o_any_valid at least one request asserted
module rr_arbitro #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_idx,
  output logic             o_any_valid
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  // Walk N_REQ slots starting at the pointer; the first hit wins
  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_any_valid = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      // One extra bit so ptr + k cannot overflow before the wrap
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!o_any_valid && i_req[w_idx]) begin
        o_any_valid  = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbitro.sv
// Purpose: shares one external 8-bit ALU between N_REQ requesters. A winner
//          is picked round-robin, its operands are registered onto the ALU,
//          the result/flags are captured one cycle later and returned with
//          the requester ID over a valid/ready response channel.
// Ports:   clk, rst                    clock, synchronous active-high reset
//          req_valid/op/a/b, req_ready per-requester request channel
//          alu_op/alu_a/alu_b          registered drive to the ALU
//          alu_result/carry/zero       ALU outputs
//          resp_valid/ready/id/result/carry/zero/err  response channel
//          op_count                    wrapping count of completed responses
module alu_arbitro
  import alu_arbitro_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_op,
  input  logic [ALU_W*N_REQ-1:0]  req_a,
  input  logic [ALU_W*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [OP_W-1:0]         alu_op,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  input  logic [RES_W-1:0]        alu_result,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [RES_W-1:0]        resp_result,
  output logic                    resp_carry,
  output logic                    resp_zero,
  output logic                    resp_err,
  output logic [CNT_W-1:0]        op_count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  alu_op_e          r_op;
  logic [ALU_W-1:0] r_a;
  logic [ALU_W-1:0] r_b;
  resp_t            r_resp;
  resp_t            w_resp_cap;
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [CNT_W-1:0] r_op_count;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any_valid;
  logic             w_accept;
  logic             w_capture;
  logic             w_handshake;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_arbitro #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_gnt       (w_gnt),
    .o_gnt_idx   (w_gnt_idx),
    .o_any_valid (w_any_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grant strobe and datapath enables
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          req_ready   = w_gnt;
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        // resp_valid is always high in this state
        if (resp_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Zero-divisor trap overrides whatever the ALU produced
  always_comb begin
    w_resp_cap = '0;
    if (is_div_op(r_op) && (r_b == '0)) begin
      w_resp_cap.err = 1'b1;
    end else begin
      w_resp_cap.result = alu_result;
      w_resp_cap.carry  = has_carry(r_op) & alu_carry;
      w_resp_cap.zero   = alu_zero;
    end
  end

  // Pointer moves past the requester just served
  always_comb begin
    w_ptr_nxt = r_id + ID_W'(1);
    if (r_id == ID_W'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end
  end

  // Operand latch, response capture, pointer and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_op         <= OP_SUM;
      r_a          <= '0;
      r_b          <= '0;
      r_resp       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_op <= alu_op_e'(req_op[OP_W*w_gnt_idx +: OP_W]);
        r_a  <= req_a[ALU_W*w_gnt_idx +: ALU_W];
        r_b  <= req_b[ALU_W*w_gnt_idx +: ALU_W];
        r_id <= w_gnt_idx;
      end
      if (w_capture) begin
        r_resp       <= w_resp_cap;
        r_resp_id    <= r_id;
        r_resp_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_resp_valid <= 1'b0;
        r_ptr        <= w_ptr_nxt;
        r_op_count   <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign alu_op      = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp.result;
  assign resp_carry  = r_resp.carry;
  assign resp_zero   = r_resp.zero;
  assign resp_err    = r_resp.err;
  assign op_count    = r_op_count;

endmodule
